code_rx_decoder: RTL and testbench
==================================

# code_rx_decoder

Serial receiver and inverse decoder for the 4-bit ABCD code. It collects the four code bits S3..S0 arriving one per qualified clock, MSB first. It maps the code back to the original A, B, C, D inputs and holds the result for a downstream consumer under a valid/ack handshake. It sits at the far end of the link driven by the encoder/serializer path and restores the original nibble.

## Interface
- No parameters; code width fixed at 4.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle frame-start strobe; arms reception of a new code
- bit_in  in  1  serial code bit, S3 first, S0 last
- bit_valid  in  1  bit_in is sampled on this cycle
- out_ack  in  1  consumer accepts the held nibble
- A, B, C, D  out  1 each  decoded nibble, registered
- out_valid  out  1  nibble held and not yet acknowledged
- overrun  out  1  sticky: a new nibble overwrote an unacknowledged one
- busy  out  1  frame in progress (state RECV)
- seg  out  7  hex display of the held nibble, {g,f,e,d,c,b,a}, active-high; present only with CODE_RX_SEG_EN

## Operation
- FSM states: IDLE, RECV.
  - IDLE: when start=1, go to RECV with bit count 0. bit_valid is ignored in IDLE.
  - RECV: each bit_valid=1 shifts bit_in into the shift register (MSB first) and increments the 2-bit count.
  - On the 4th bit, the code {S3,S2,S1,S0} is decoded, loaded into A..D, out_valid is set, and the FSM returns to IDLE.
  - start=1 in RECV discards the partial code and restarts at count 0. This holds even if bit_valid=1 in the same cycle; that bit is dropped.
- Inverse map, code -> ABCD:
  - 0->1001, 1->1100, 2->0101, 3->1101
  - 4->1110, 5->0100, 6->0010, 7->1000
  - 8->1010, 9->0001, A->1011, B->0000
  - C->0110, D->1111, E->0111, F->0011
- The map is a bijection; every code decodes and there is no error case.
- Handshake:
  - out_valid stays 1 and A..D stay stable until out_ack=1.
  - out_ack with out_valid=1 clears out_valid on the next edge. A..D keep their last value.
  - out_ack with out_valid=0 is ignored.
- Simultaneous load and ack on the same edge: the load wins. out_valid stays 1, the new nibble is presented, and overrun is not set.
- Load while out_valid=1 and out_ack=0: the new nibble overwrites the old one, out_valid stays 1, and overrun is set.
- overrun clears only on reset.

## Timing
- Reset values: A=B=C=D=0, out_valid=0, overrun=0, busy=0, state=IDLE, count=0, shift register=0, seg=7'b0111111.
- reset mid-frame aborts the frame immediately and asynchronously. The held nibble is lost.
- start sampled at edge N: busy=1 after edge N. The first bit can be sampled at edge N+1.
- Latency: the 4th bit sampled at edge M updates A..D and out_valid after edge M (0 cycles beyond the last bit). busy=0 after edge M.
- Minimum frame is 5 cycles (start plus 4 bits). Back-to-back frames need a new start. Gaps between bits (bit_valid=0) are allowed indefinitely.

## Configuration
- CODE_RX_SEG_EN defined:
  - The seg port exists and is registered from the held nibble, updating on the same edge as A..D.
  - Patterns, hex: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- CODE_RX_SEG_EN undefined: the seg port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package code_pkg holds:
  - FSM state enum (IDLE, RECV)
  - CODE_W=4
  - inverse code table constant
  - 7-segment hex pattern constant
- One sub-module, code_inv_lut: combinational 4-bit code -> ABCD lookup, instantiated once. The encoder bench also reuses it as a round-trip checker.

## Test plan
- Reset, then start, then bits 1,0,1,1 (code B) -> ABCD=0000, out_valid=1; with CODE_RX_SEG_EN, seg=3F.
- Sweep all 16 codes, each acknowledged -> ABCD matches the inverse map; encoding the result reproduces the sent code.
- Bits 1,1 with bit_valid gaps of 3 cycles, then start, then 0,1,1,1 (code 7) -> ABCD=1000. The partial frame is discarded.
- Two frames, code 9 then code 2, with no ack between -> ABCD=0101, overrun=1. Repeat with out_ack asserted on the second frame's load edge -> overrun stays 0, out_valid=1.
- reset asserted after 2 bits, off a clock edge -> all outputs at reset values immediately. The next full frame of code 0 gives ABCD=1001.
- bit_valid pulses in IDLE with no start -> no state change, out_valid stays 0.

Source files
------------

// File: rtl/code_pkg.sv
// Shared definitions for the ABCD code receive path: code width, FSM states,
// the inverse code table and the 7-segment hex patterns.
package code_pkg;

    localparam int CODE_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Inverse code table, indexed by code {S3,S2,S1,S0}, giving {A,B,C,D}.
    // Listed from index 15 down to index 0.
    localparam logic [15:0][CODE_W-1:0] INV_TABLE = {
        4'b0011, 4'b0111, 4'b1111, 4'b0110,   // F E D C
        4'b0000, 4'b1011, 4'b0001, 4'b1010,   // B A 9 8
        4'b1000, 4'b0010, 4'b0100, 4'b1110,   // 7 6 5 4
        4'b1101, 4'b0101, 4'b1100, 4'b1001    // 3 2 1 0
    };

    // Hex digit patterns {g,f,e,d,c,b,a}, active-high, index 15 down to 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,           // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,           // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,           // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F            // 3 2 1 0
    };

    // Display pattern for the cleared nibble (digit 0).
    localparam logic [6:0] SEG_RESET = 7'h3F;

endpackage

// File: rtl/code_rx_decoder_if.sv
// Serial input / decoded output bundle of code_rx_decoder.
// The seg field exists only when CODE_RX_SEG_EN is defined.
interface code_rx_decoder_if;

    logic       start;
    logic       bit_in;
    logic       bit_valid;
    logic       out_ack;
    logic       A;
    logic       B;
    logic       C;
    logic       D;
    logic       out_valid;
    logic       overrun;
    logic       busy;
`ifdef CODE_RX_SEG_EN
    logic [6:0] seg;
`endif

    // Link/consumer side: drives the serial stream and the acknowledge.
    modport master (
        output start, bit_in, bit_valid, out_ack,
`ifdef CODE_RX_SEG_EN
        input  seg,
`endif
        input  A, B, C, D, out_valid, overrun, busy
    );

    // Decoder side.
    modport slave (
        input  start, bit_in, bit_valid, out_ack,
`ifdef CODE_RX_SEG_EN
        output seg,
`endif
        output A, B, C, D, out_valid, overrun, busy
    );

endinterface

// File: rtl/code_rx_decoder_inv_lut.sv
// code_inv_lut: combinational 4-bit code -> {A,B,C,D} lookup.
// Reusable on its own as a round-trip checker for the encoder.
module code_inv_lut
    import code_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [CODE_W-1:0] abcd
);

    // Table lookup; the map is a bijection so every code has an entry.
    always_comb begin
        abcd = INV_TABLE[code];
    end

endmodule

// File: rtl/code_rx_decoder.sv
// code_rx_decoder: collects a 4-bit ABCD code serially (S3 first), decodes it
// back to the original nibble and holds it under a valid/ack handshake.
// Optional feature macro: CODE_RX_SEG_EN adds a registered 7-segment output.
module code_rx_decoder
    import code_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    code_rx_decoder_if.slave   rx
);

    state_t              state_r;
    state_t              state_n;
    logic [1:0]          count_r;
    logic [1:0]          count_n;
    // Only S3..S1 need storing; S0 is combined directly on the last bit.
    logic [CODE_W-2:0]   shift_r;
    logic [CODE_W-2:0]   shift_n;
    logic [CODE_W-1:0]   code_s;
    logic [CODE_W-1:0]   abcd_s;
    logic                load_s;
    logic [CODE_W-1:0]   abcd_r;
    logic                out_valid_r;
    logic                overrun_r;
    logic                busy_r;

    assign code_s = {shift_r, rx.bit_in};

    code_inv_lut u_inv_lut (
        .code (code_s),
        .abcd (abcd_s)
    );

    // Next-state logic: frame arming, bit collection and final load strobe.
    always_comb begin
        state_n = state_r;
        count_n = count_r;
        shift_n = shift_r;
        load_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (rx.start) begin
                    state_n = RECV;
                    count_n = 2'd0;
                    shift_n = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            RECV: begin
                if (rx.start) begin
                    // Restart wins over a coincident bit; that bit is dropped.
                    state_n = RECV;
                    count_n = 2'd0;
                    shift_n = '0;
                end else if (rx.bit_valid) begin
                    shift_n = code_s[CODE_W-2:0];
                    count_n = count_r + 2'd1;
                    if (count_r == 2'd3) begin
                        load_s  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = RECV;
                    end
                end else begin
                    state_n = RECV;
                end
            end
            default: begin
                state_n = IDLE;
                count_n = 2'd0;
                shift_n = '0;
            end
        endcase
    end

    // FSM, bit counter, shift register and registered busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            count_r <= 2'd0;
            shift_r <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            count_r <= count_n;
            shift_r <= shift_n;
            busy_r  <= (state_n == RECV);
        end
    end

    // Held nibble and handshake flags; a load beats a coincident ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abcd_r      <= 4'b0000;
            out_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else if (load_s) begin
            abcd_r      <= abcd_s;
            out_valid_r <= 1'b1;
            if (out_valid_r && !rx.out_ack) begin
                overrun_r <= 1'b1;
            end
        end else if (out_valid_r && rx.out_ack) begin
            out_valid_r <= 1'b0;
        end
    end

`ifdef CODE_RX_SEG_EN
    logic [6:0] seg_r;

    // Hex display of the held nibble, updated on the same edge as A..D.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_r <= SEG_RESET;
        end else if (load_s) begin
            seg_r <= SEG_TABLE[abcd_s];
        end
    end

    assign rx.seg = seg_r;
`endif

    assign rx.A         = abcd_r[3];
    assign rx.B         = abcd_r[2];
    assign rx.C         = abcd_r[1];
    assign rx.D         = abcd_r[0];
    assign rx.out_valid = out_valid_r;
    assign rx.overrun   = overrun_r;
    assign rx.busy      = busy_r;

endmodule

// File: tb/tb_code_rx_decoder.sv
// Directed, table-driven bench for code_rx_decoder.
module tb_code_rx_decoder;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    code_rx_decoder_if ifc ();

    code_rx_decoder dut (
        .clk   (clk),
        .reset (reset),
        .rx    (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] code;
        logic [3:0] abcd;
        logic [6:0] seg;
    } vec_t;

    vec_t       tbl [16];
    logic [3:0] enc [16];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: inputs applied now, sampled at the next rising edge; returns 1 time unit after it.
    task automatic step(input logic s, input logic v, input logic b, input logic a);
        ifc.start     = s;
        ifc.bit_valid = v;
        ifc.bit_in    = b;
        ifc.out_ack   = a;
        @(posedge clk);
        #1;
        ifc.start     = 1'b0;
        ifc.bit_valid = 1'b0;
        ifc.bit_in    = 1'b0;
        ifc.out_ack   = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] code, input logic ack_last);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            step(1'b0, 1'b1, code[i], (ack_last && i == 0));
        end
    endtask

    function automatic logic [3:0] abcd_now();
        return {ifc.A, ifc.B, ifc.C, ifc.D};
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".abcd"},      {4'h0, abcd_now()}, 8'h00);
        chk({tag, ".out_valid"}, {7'h0, ifc.out_valid}, 8'h00);
        chk({tag, ".overrun"},   {7'h0, ifc.overrun}, 8'h00);
        chk({tag, ".busy"},      {7'h0, ifc.busy}, 8'h00);
`ifdef CODE_RX_SEG_EN
        chk({tag, ".seg"},       {1'b0, ifc.seg}, 8'h3F);
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        tbl[0]  = '{4'h0, 4'b1001, 7'h6F};
        tbl[1]  = '{4'h1, 4'b1100, 7'h39};
        tbl[2]  = '{4'h2, 4'b0101, 7'h6D};
        tbl[3]  = '{4'h3, 4'b1101, 7'h5E};
        tbl[4]  = '{4'h4, 4'b1110, 7'h79};
        tbl[5]  = '{4'h5, 4'b0100, 7'h66};
        tbl[6]  = '{4'h6, 4'b0010, 7'h5B};
        tbl[7]  = '{4'h7, 4'b1000, 7'h7F};
        tbl[8]  = '{4'h8, 4'b1010, 7'h77};
        tbl[9]  = '{4'h9, 4'b0001, 7'h06};
        tbl[10] = '{4'hA, 4'b1011, 7'h7C};
        tbl[11] = '{4'hB, 4'b0000, 7'h3F};
        tbl[12] = '{4'hC, 4'b0110, 7'h7D};
        tbl[13] = '{4'hD, 4'b1111, 7'h71};
        tbl[14] = '{4'hE, 4'b0111, 7'h07};
        tbl[15] = '{4'hF, 4'b0011, 7'h4F};
        // Forward encoder ABCD -> code, written out independently for the round trip.
        enc[0]  = 4'hB; enc[1]  = 4'h9; enc[2]  = 4'h6; enc[3]  = 4'hF;
        enc[4]  = 4'h5; enc[5]  = 4'h2; enc[6]  = 4'hC; enc[7]  = 4'hE;
        enc[8]  = 4'h7; enc[9]  = 4'h0; enc[10] = 4'h8; enc[11] = 4'hA;
        enc[12] = 4'h1; enc[13] = 4'h3; enc[14] = 4'h4; enc[15] = 4'hD;

        ifc.start = 1'b0; ifc.bit_valid = 1'b0; ifc.bit_in = 1'b0; ifc.out_ack = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_reset_vals("rst");
        reset = 1'b0;

        // Code B: busy after start, clear after the 4th bit, ABCD=0000.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("b.busy_start", {7'h0, ifc.busy}, 8'h01);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("b.valid_early", {7'h0, ifc.out_valid}, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("b.abcd",  {4'h0, abcd_now()}, 8'h00);
        chk("b.valid", {7'h0, ifc.out_valid}, 8'h01);
        chk("b.busy",  {7'h0, ifc.busy}, 8'h00);
`ifdef CODE_RX_SEG_EN
        chk("b.seg",   {1'b0, ifc.seg}, 8'h3F);
`endif
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Sweep all codes, each acknowledged.
        for (int k = 0; k < 16; k++) begin
            send_frame(tbl[k].code, 1'b0);
            chk($sformatf("sw%0h.abcd", k),  {4'h0, abcd_now()}, {4'h0, tbl[k].abcd});
            chk($sformatf("sw%0h.valid", k), {7'h0, ifc.out_valid}, 8'h01);
            chk($sformatf("sw%0h.round", k), {4'h0, enc[abcd_now()]}, {4'h0, tbl[k].code});
`ifdef CODE_RX_SEG_EN
            chk($sformatf("sw%0h.seg", k),   {1'b0, ifc.seg}, {1'b0, tbl[k].seg});
`endif
            step(1'b0, 1'b0, 1'b0, 1'b1);
            chk($sformatf("sw%0h.ackd", k),  {7'h0, ifc.out_valid}, 8'h00);
            chk($sformatf("sw%0h.hold", k),  {4'h0, abcd_now()}, {4'h0, tbl[k].abcd});
        end
        chk("sw.overrun", {7'h0, ifc.overrun}, 8'h00);

        // bit_valid in IDLE without start is ignored; stray ack also ignored.
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 1'b1, k[0]);
        chk("idle.valid", {7'h0, ifc.out_valid}, 8'h00);
        chk("idle.busy",  {7'h0, ifc.busy}, 8'h00);
        chk("idle.abcd",  {4'h0, abcd_now()}, 8'h03);

        // Partial frame with gaps, restarted by start coinciding with a bit.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("part.busy", {7'h0, ifc.busy}, 8'h01);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("part.valid_early", {7'h0, ifc.out_valid}, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("part.abcd",  {4'h0, abcd_now()}, 8'h08);
        chk("part.valid", {7'h0, ifc.out_valid}, 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Code 9 unacked (held across idle cycles), then code 2 overwrites it.
        send_frame(4'h9, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr.hold_valid", {7'h0, ifc.out_valid}, 8'h01);
        chk("ovr.hold_abcd",  {4'h0, abcd_now()}, 8'h01);
        send_frame(4'h2, 1'b0);
        chk("ovr.abcd",    {4'h0, abcd_now()}, 8'h05);
        chk("ovr.overrun", {7'h0, ifc.overrun}, 8'h01);
        chk("ovr.valid",   {7'h0, ifc.out_valid}, 8'h01);

        // Reset off a clock edge after two bits.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("amid");
        #1;
        reset = 1'b0;
        send_frame(4'h0, 1'b0);
        chk("post.abcd",  {4'h0, abcd_now()}, 8'h09);
        chk("post.valid", {7'h0, ifc.out_valid}, 8'h01);

        // Load with ack on the same edge (from a held, unacked nibble): no overrun.
        send_frame(4'h9, 1'b0);
        chk("la.ovr9", {7'h0, ifc.overrun}, 8'h01);
        reset = 1'b1;
        #3;
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(4'h9, 1'b0);
        send_frame(4'h2, 1'b1);
        chk("la.abcd",    {4'h0, abcd_now()}, 8'h05);
        chk("la.valid",   {7'h0, ifc.out_valid}, 8'h01);
        chk("la.overrun", {7'h0, ifc.overrun}, 8'h00);
`ifdef CODE_RX_SEG_EN
        chk("la.seg",     {1'b0, ifc.seg}, 8'h6D);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
